// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation controller (ports: clk, rst, start, abort, Op/Om comparator -> B/BN trial code, D result, busy, done, timeout_err, bit_idx)
module sar_ctrl #(
  parameter int WIDTH        = 8,
  parameter int MSB_FIRST    = 1,
  parameter int AUTO_RESTART = 0,
  parameter int TIMEOUT      = 15,
  localparam int IW          = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             Op,
  input  logic             Om,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] BN,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [IW-1:0]    bit_idx
);
  localparam logic [IW-1:0] FIRST = MSB_FIRST != 0 ? IW'(WIDTH - 1) : '0;
  localparam logic [IW-1:0] LAST  = MSB_FIRST != 0 ? '0 : IW'(WIDTH - 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d, d_q, d_d, kept;
  logic done_q, done_d, terr_q, terr_d, tmo, res;
  logic [IW-1:0] idx_q, idx_d, idx_nx;
  logic [7:0] wcnt_q, wcnt_d;
  always_comb begin
    tmo = ~Op & ~Om & (wcnt_q == 8'(TIMEOUT - 1));
    res = Op | Om | tmo;
    idx_nx = MSB_FIRST != 0 ? idx_q - 1'b1 : idx_q + 1'b1;
    kept = b_q;
    kept[idx_q] = Op;
    state_d = state_q;
    b_d = b_q;
    d_d = d_q;
    done_d = 1'b0;
    terr_d = terr_q;
    idx_d = idx_q;
    wcnt_d = wcnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CONV;
        b_d = '0;
        b_d[FIRST] = 1'b1;
        idx_d = FIRST;
        terr_d = 1'b0;
        wcnt_d = '0;
      end
    end else if (abort) begin
      state_d = IDLE;
      b_d = '0;
      wcnt_d = '0;
    end else if (!res) begin
      wcnt_d = wcnt_q + 8'd1;
    end else begin
      wcnt_d = '0;
      terr_d = terr_q | tmo;
      b_d = kept;
      if (idx_q == LAST) begin
        d_d = kept;
        done_d = 1'b1;
        if (AUTO_RESTART != 0) begin
          b_d = '0;
          b_d[FIRST] = 1'b1;
          idx_d = FIRST;
          terr_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        b_d[idx_nx] = 1'b1;
        idx_d = idx_nx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q <= '0;
      d_q <= '0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
      idx_q <= '0;
      wcnt_q <= '0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      d_q <= d_d;
      done_q <= done_d;
      terr_q <= terr_d;
      idx_q <= idx_d;
      wcnt_q <= wcnt_d;
    end
  end
  assign B = b_q;
  assign BN = ~b_q;
  assign D = d_q;
  assign busy = state_q == CONV;
  assign done = done_q;
  assign timeout_err = terr_q;
  assign bit_idx = idx_q;
endmodule

// File: tb/tb_sar_ctrl.sv
// tb_sar_ctrl: randomized check of two sar_ctrl configurations against a bit-trial reference model
module tb_sar_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic op0, om0, op1, om1;
  logic [7:0] b0, bn0, d0, b1, bn1, d1;
  logic busy0, done0, terr0, busy1, done1, terr1;
  logic [2:0] idx0, idx1;
  int n_chk = 0, n_pass = 0, mode = 0, vin = 0;
  typedef struct {bit conv; int b; int d; bit done; bit terr; int k; int wt;} mdl_t;
  mdl_t m0, m1;
  always #5 clk = ~clk;
  sar_ctrl #(.WIDTH(8), .MSB_FIRST(1), .AUTO_RESTART(0), .TIMEOUT(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .Op(op0), .Om(om0),
    .B(b0), .BN(bn0), .D(d0), .busy(busy0), .done(done0), .timeout_err(terr0), .bit_idx(idx0));
  sar_ctrl #(.WIDTH(8), .MSB_FIRST(0), .AUTO_RESTART(1), .TIMEOUT(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .Op(op1), .Om(om1),
    .B(b1), .BN(bn1), .D(d1), .busy(busy1), .done(done1), .timeout_err(terr1), .bit_idx(idx1));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask
  function automatic int bp(input int k, input bit msb);
    return msb ? 7 - k : k;
  endfunction
  function automatic mdl_t step(input mdl_t m, input bit r, s, a, op, om, msb, ar, input int to);
    mdl_t n = m;
    n.done = 0;
    if (r) begin
      n = '{default: 0};
    end else if (!m.conv) begin
      if (s) begin
        n.conv = 1; n.k = 0; n.b = 1 << bp(0, msb); n.terr = 0; n.wt = 0;
      end
    end else if (a) begin
      n.conv = 0; n.b = 0; n.wt = 0;
    end else if (!op && !om && m.wt + 1 < to) begin
      n.wt = m.wt + 1;
    end else begin
      if (!op) n.b = m.b & ~(1 << bp(m.k, msb));
      if (!op && !om) n.terr = 1;
      n.wt = 0;
      if (m.k == 7) begin
        n.d = n.b; n.done = 1;
        if (ar) begin
          n.k = 0; n.b = 1 << bp(0, msb); n.terr = 0;
        end else n.conv = 0;
      end else begin
        n.k = m.k + 1; n.b = n.b | (1 << bp(n.k, msb));
      end
    end
    return n;
  endfunction
  task automatic drive_cmp(input int b, input int r, output logic op, output logic om);
    if (mode == 2 || (mode == 1 && r == 0)) begin op = 0; om = 0; end
    else if (mode == 1 && r == 1) begin op = 1; om = 1; end
    else if (mode == 3) begin op = 1; om = 0; end
    else begin op = vin >= b; om = !(vin >= b); end
  endtask
  task automatic compare(input string p, input mdl_t m, input logic [7:0] b, bn, d,
                         input logic busy, done, terr, input logic [2:0] idx, input bit msb);
    chk({p, "_b"}, b, m.b);
    chk({p, "_bn"}, bn, ~m.b & 'hFF);
    chk({p, "_d"}, d, m.d);
    chk({p, "_busy"}, busy, m.conv);
    chk({p, "_done"}, done, m.done);
    chk({p, "_terr"}, terr, m.terr);
    if (m.conv) chk({p, "_idx"}, idx, bp(m.k, msb));
  endtask
  task automatic cyc();
    int r = $urandom % 4;
    drive_cmp(m0.b, r, op0, om0);
    drive_cmp(m1.b, r, op1, om1);
    @(posedge clk);
    m0 = step(m0, rst, start, abort, op0, om0, 1, 0, 4);
    m1 = step(m1, rst, start, abort, op1, om1, 0, 1, 3);
    @(negedge clk);
    compare("u0", m0, b0, bn0, d0, busy0, done0, terr0, idx0, 1);
    compare("u1", m1, b1, bn1, d1, busy1, done1, terr1, idx1, 0);
  endtask
  task automatic conv_run(input int v, input int md, input int n);
    vin = v; mode = md; start = 1;
    cyc();
    start = 0;
    repeat (n) cyc();
  endtask
  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    repeat (2) cyc();
    chk("rst_idx", idx0, 0);
    rst = 0;
    vin = 'hA5; mode = 0; start = 1;
    cyc();
    start = 0;
    chk("a5_first", b0, 'h80);
    repeat (7) cyc();
    chk("a5_nodone_early", done0, 0);
    cyc();
    chk("a5_done", done0, 1);
    chk("a5_d", d0, 'hA5);
    chk("a5_bn", bn0, 'h5A);
    repeat (4) cyc();
    conv_run('h00, 2, 32);
    chk("tmo_d", d0, 'h00);
    chk("tmo_terr", terr0, 1);
    conv_run('h3C, 0, 2);
    abort = 1;
    cyc();
    abort = 0;
    chk("abort_b", b0, 0);
    chk("abort_busy", busy0, 0);
    repeat (8) cyc();
    chk("abort_d_kept", d0, 'h00);
    conv_run('h00, 3, 10);
    for (int i = 0; i < 4000; i++) begin
      if (i % 20 == 0) vin = $urandom % 256;
      if (i % 50 == 0) mode = $urandom % 4;
      start = ($urandom % 4) == 0;
      abort = ($urandom % 40) == 0;
      rst = ($urandom % 300) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
